// File: rtl/reg_scoreboard.sv
// Latency-driven register scoreboard: per-register countdowns of in-flight writes,
// Decode stall generation for RAW and WAW hazards, and one-cycle cancel rollback.
module reg_scoreboard #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int NSRC   = 4,
  parameter int CW     = 3,
  parameter int FWD_OK = 1,
  parameter int PC_REG = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC*AW-1:0]   src_addr,
  input  logic [NSRC-1:0]      src_valid,
  input  logic                 issue_valid,
  input  logic                 kill,
  input  logic [AW-1:0]        dst0_addr,
  input  logic [AW-1:0]        dst1_addr,
  input  logic                 dst0_we,
  input  logic                 dst1_we,
  input  logic [CW-1:0]        dst0_lat,
  input  logic [CW-1:0]        dst1_lat,
  input  logic                 cancel,
  output logic                 stall,
  output logic                 issued,
  output logic [NREG-1:0]      busy,
  output logic [15:0]          stall_cycles
);

  localparam logic [CW-1:0] FWD_LIM = CW'(FWD_OK);
  localparam logic [15:0]   SAT_MAX = 16'hFFFF;

  logic [CW-1:0]   count_q [NREG];
  logic [CW-1:0]   count_d [NREG];
  logic [CW-1:0]   prev_q  [NREG];
  logic [CW-1:0]   prev_d  [NREG];
  logic [NREG-1:0] young_q;
  logic [NREG-1:0] young_d;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [15:0]     stall_cycles_q;
  logic [15:0]     stall_cycles_d;

  logic [NSRC-1:0] src_blk_s;
  logic            waw0_blk_s;
  logic            waw1_blk_s;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] x);
    if (x != '0) begin
      return x - CW'(1);
    end else begin
      return '0;
    end
  endfunction

  // The PC register and any address beyond NREG are never tracked.
  function automatic logic tracked(input logic [AW-1:0] a);
    return (int'(a) != PC_REG) && (int'(a) < NREG);
  endfunction

  function automatic logic [CW-1:0] cnt_of(input logic [AW-1:0] a);
    if (tracked(a)) begin
      return count_q[a];
    end else begin
      return '0;
    end
  endfunction

  // Hazard detection: RAW beyond forwarding reach, and WAW overtaking an older write.
  always_comb begin
    src_blk_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      src_blk_s[i] = src_valid[i] & tracked(src_addr[i*AW +: AW]) &
                     (cnt_of(src_addr[i*AW +: AW]) > FWD_LIM);
    end
    waw0_blk_s = dst0_we & tracked(dst0_addr) & (cnt_of(dst0_addr) > dst0_lat);
    waw1_blk_s = dst1_we & tracked(dst1_addr) & (cnt_of(dst1_addr) > dst1_lat);
    stall  = issue_valid & ~kill & ((|src_blk_s) | waw0_blk_s | waw1_blk_s);
    issued = issue_valid & ~kill & ~stall;
  end

  // Per-register next state: issue load beats cancel rollback beats plain decrement.
  always_comb begin
    logic h0;
    logic h1;
    h0 = 1'b0;
    h1 = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      h0 = issued & dst0_we & (dst0_addr == AW'(r)) & (dst0_lat != '0);
      h1 = issued & dst1_we & (dst1_addr == AW'(r)) & (dst1_lat != '0);
      count_d[r] = dec(count_q[r]);
      prev_d[r]  = prev_q[r];
      young_d[r] = 1'b0;
      if (r == PC_REG) begin
        count_d[r] = '0;
        prev_d[r]  = '0;
      end else if (h0 || h1) begin
        prev_d[r]  = dec(count_q[r]);
        young_d[r] = 1'b1;
        if (h0 && h1) begin
          count_d[r] = (dst0_lat > dst1_lat) ? dst0_lat : dst1_lat;
        end else if (h0) begin
          count_d[r] = dst0_lat;
        end else begin
          count_d[r] = dst1_lat;
        end
      end else if (cancel && young_q[r]) begin
        count_d[r] = dec(prev_q[r]);
      end else begin
        count_d[r] = dec(count_q[r]);
      end
      busy_d[r] = (count_d[r] != '0);
    end
    if (stall && (stall_cycles_q != SAT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        count_q[r] <= '0;
        prev_q[r]  <= '0;
      end
      young_q        <= '0;
      busy_q         <= '0;
      stall_cycles_q <= 16'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        count_q[r] <= count_d[r];
        prev_q[r]  <= prev_d[r];
      end
      young_q        <= young_d;
      busy_q         <= busy_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy         = busy_q;
  assign stall_cycles = stall_cycles_q;

endmodule
